pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 42 ++++
 rtl/pc_ras.sv | 69 ++++++
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and constants for the PC sequencer: sequencer
//                state encoding, default reset/exception vectors, next-PC
//                select encoding and the branch-condition helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

   // Default vectors; the top-level parameters resize these to ADDR_W.
   localparam logic [31:0] c_reset_vec = 32'h0000_0000;
   localparam logic [31:0] c_exc_vec   = 32'h8000_0180;

   // Sequencer state: BOOT after reset, RUN while fetching, TRAP for the
   // single cycle following an exception.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } pc_state_e;

   // Source of the next PC value.
   typedef enum logic [2:0] {
      SEL_HOLD   = 3'd0,
      SEL_EXC    = 3'd1,
      SEL_JR     = 3'd2,
      SEL_RET    = 3'd3,
      SEL_JUMP   = 3'd4,
      SEL_BRANCH = 3'd5,
      SEL_SEQ    = 3'd6
   } pc_sel_e;

   // BEQ is taken on zero=1, BNE on zero=0.
   function automatic logic branch_taken(input logic br, input logic ne, input logic z);
      return br & (z ^ ne);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack. A push when full overwrites
//                the oldest entry; a pop when empty leaves the stack
//                unchanged. top_o is the most recently pushed live entry.
//                Only instantiated when PC_SEQUENCER_RAS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ras #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int                c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w + 1)'(DEPTH);

   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w:0]   count_q,  count_d;
   logic [W-1:0]       mem_q [DEPTH];
   logic [c_ptr_w-1:0] w_top_idx;

   assign w_top_idx = wr_ptr_q - 1'b1;
   assign top_o     = mem_q[w_top_idx];
   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == c_full);

   // Pointer/occupancy update; the count saturates so the pointer simply wraps.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (!full_o) count_d = count_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         wr_ptr_d = wr_ptr_q - 1'b1;
         count_d  = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers; reset empties the stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while the stack is empty.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : MIPS-style program-counter sequencer. BOOT/RUN/TRAP FSM with
//                prioritised next-PC selection (exc > stall > jr > jump >
//                taken branch > pc+4). Optional return-address stack enabled
//                by defining PC_SEQUENCER_RAS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_reset_vec),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(c_exc_vec),
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic              branch_ne_i,
   input  logic              zero_i,
   input  logic [31:0]       imm_ext_i,
   input  logic              jump_i,
   input  logic              jump_link_i,
   input  logic [25:0]       jump_target_i,
   input  logic              jr_i,
   input  logic              jr_ret_i,
   input  logic [ADDR_W-1:0] jr_addr_i,
   input  logic              exc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic              pc_valid_o,
   output logic [ADDR_W-1:0] epc_o,
   output logic              ras_empty_o
);

   pc_state_e         state_q, state_d;
   pc_sel_e           w_sel;
   logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
   logic [ADDR_W-1:0] w_plus4, w_imm_sh, w_br_tgt, w_jmp_tgt, w_jr_tgt, w_ras_top;
   logic              w_push, w_pop, w_ret_hit;
   logic              w_unused_ok;

   // Candidate targets; all arithmetic wraps modulo 2^ADDR_W.
   assign w_plus4  = pc_q + ADDR_W'(4);
   assign w_imm_sh = ADDR_W'($signed({imm_ext_i, 2'b00}));
   assign w_br_tgt = w_plus4 + w_imm_sh;
   assign w_jr_tgt = {jr_addr_i[ADDR_W-1:2], 2'b00};

   // Jump target keeps the upper bits of pc+4 and replaces the low 28 bits.
   always_comb begin
      w_jmp_tgt       = w_plus4;
      w_jmp_tgt[27:0] = {jump_target_i, 2'b00};
   end

`ifdef PC_SEQUENCER_RAS_EN
   logic w_ras_empty;
   logic w_ras_full_unused;

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (w_plus4),
      .top_o   (w_ras_top),
      .empty_o (w_ras_empty),
      .full_o  (w_ras_full_unused)
   );

   // A return only takes the stacked address when one is available.
   assign w_ret_hit   = jr_ret_i & ~w_ras_empty;
   assign ras_empty_o = w_ras_empty;
   assign w_unused_ok = ^jr_addr_i[1:0];
`else
   logic [31:0] w_depth_unused;

   assign w_ras_top      = '0;
   assign w_ret_hit      = 1'b0;
   assign ras_empty_o    = 1'b0;
   assign w_depth_unused = RAS_DEPTH;
   assign w_unused_ok    = ^{jr_addr_i[1:0], w_push, w_pop};
`endif

   // Next-state and next-PC source selection in priority order.
   always_comb begin
      state_d = state_q;
      w_sel   = SEL_HOLD;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_TRAP: state_d = ST_RUN;
         ST_RUN: begin
            if (exc_i) begin
               w_sel   = SEL_EXC;
               state_d = ST_TRAP;
            end else if (stall_i) begin
               w_sel = SEL_HOLD;
            end else if (jr_i) begin
               w_sel = w_ret_hit ? SEL_RET : SEL_JR;
               w_pop = jr_ret_i;
            end else if (jump_i || jump_link_i) begin
               w_sel  = SEL_JUMP;
               w_push = jump_link_i;
            end else if (branch_taken(branch_i, branch_ne_i, zero_i)) begin
               w_sel = SEL_BRANCH;
            end else begin
               w_sel = SEL_SEQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // PC/EPC next-value mux driven by the selected source.
   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      case (w_sel)
         SEL_EXC: begin
            epc_d = pc_q;
            pc_d  = EXC_VEC;
         end
         SEL_JR:     pc_d = w_jr_tgt;
         SEL_RET:    pc_d = w_ras_top;
         SEL_JUMP:   pc_d = w_jmp_tgt;
         SEL_BRANCH: pc_d = w_br_tgt;
         SEL_SEQ:    pc_d = w_plus4;
         default:    pc_d = pc_q;
      endcase
   end

   // State, PC and EPC registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = w_plus4;
   assign pc_valid_o = (state_q == ST_RUN);
   assign epc_o      = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer: directed vector table,
//                hand-written multi-cycle sequences and a randomized run
//                against a queue-based behavioural model. Adapts its
//                expectations to PC_SEQUENCER_RAS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;

   localparam int ADDR_W    = 32;
   localparam int RAS_DEPTH = 4;
`ifdef PC_SEQUENCER_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif
   localparam logic [31:0] RST_V = 32'h0000_0000;
   localparam logic [31:0] EXC_V = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst, stall, branch, branch_ne, zero, jump, jump_link, jr, jr_ret, exc;
   logic [31:0] imm_ext, jr_addr;
   logic [25:0] jump_target;
   logic [31:0] pc, pc_plus4, epc;
   logic        pc_valid, ras_empty;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer #(
      .ADDR_W    (ADDR_W),
      .RESET_VEC (RST_V),
      .EXC_VEC   (EXC_V),
      .RAS_DEPTH (RAS_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall),
      .branch_i      (branch),
      .branch_ne_i   (branch_ne),
      .zero_i        (zero),
      .imm_ext_i     (imm_ext),
      .jump_i        (jump),
      .jump_link_i   (jump_link),
      .jump_target_i (jump_target),
      .jr_i          (jr),
      .jr_ret_i      (jr_ret),
      .jr_addr_i     (jr_addr),
      .exc_i         (exc),
      .pc_o          (pc),
      .pc_plus4_o    (pc_plus4),
      .pc_valid_o    (pc_valid),
      .epc_o         (epc),
      .ras_empty_o   (ras_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [31:0] start;
      logic        br, ne, z;
      logic [31:0] imm;
      logic        jmp;
      logic [25:0] jt;
      logic        jrq;
      logic [31:0] jra;
      logic        ex, stl;
      logic [31:0] exp_pc;
      logic        exp_v;
   } vec_t;

   vec_t vecs[$];

   // behavioural model: 0=boot 1=run 2=trap
   int          m_mode;
   logic [31:0] m_pc, m_epc;
   logic [31:0] m_ras[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      stall = 0; branch = 0; branch_ne = 0; zero = 0; imm_ext = '0;
      jump = 0; jump_link = 0; jump_target = '0; jr = 0; jr_ret = 0;
      jr_addr = '0; exc = 0;
   endtask

   // Steer the DUT to a given PC with a plain register jump.
   task automatic goto(input logic [31:0] a);
      if (!pc_valid) tick;
      jr = 1; jr_addr = a;
      tick;
      clear_inputs();
   endtask

   function automatic vec_t mk(input string n, input logic [31:0] s,
                               input logic br, input logic ne, input logic z, input logic [31:0] imm,
                               input logic jmp, input logic [25:0] jt,
                               input logic jrq, input logic [31:0] jra,
                               input logic ex, input logic stl,
                               input logic [31:0] ep, input logic ev);
      vec_t v;
      v.name = n; v.start = s; v.br = br; v.ne = ne; v.z = z; v.imm = imm;
      v.jmp = jmp; v.jt = jt; v.jrq = jrq; v.jra = jra; v.ex = ex; v.stl = stl;
      v.exp_pc = ep; v.exp_v = ev;
      return v;
   endfunction

   task automatic model_reset;
      m_mode = 0; m_pc = RST_V; m_epc = '0;
      m_ras.delete();
   endtask

   // Next-state rules computed directly from the architectural description.
   task automatic model_step;
      logic [31:0] nxt;
      if (rst) begin
         model_reset();
      end else if (m_mode != 1) begin
         m_mode = 1;
      end else if (exc) begin
         m_epc = m_pc; m_pc = EXC_V; m_mode = 2;
      end else if (stall) begin
         // nothing moves
      end else if (jr) begin
         if (RAS_ON && jr_ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
         else m_pc = jr_addr & 32'hFFFF_FFFC;
      end else if (jump || jump_link) begin
         nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_target) << 2);
         if (RAS_ON && jump_link) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
         end
         m_pc = nxt;
      end else if (branch && (zero != branch_ne)) begin
         m_pc = m_pc + 32'd4 + (imm_ext << 2);
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   initial begin
      logic [31:0] ret_exp [5];
      logic        emp_exp [5];
      int          simm;

      clear_inputs();
      rst = 1;

      // ---------------- reset and boot sequence ----------------
      tick; tick;
      check("rst_pc", pc, RST_V);
      check("rst_valid", pc_valid, 1'b0);
      check("rst_epc", epc, 32'h0);
      check("rst_ras_empty", ras_empty, RAS_ON ? 1'b1 : 1'b0);
      rst = 0;
      tick;
      check("boot_run_pc", pc, 32'h0);
      check("boot_run_valid", pc_valid, 1'b1);
      tick; check("seq_pc4", pc, 32'h4);
      tick; check("seq_pc8", pc, 32'h8);
      tick; check("seq_pcC", pc, 32'hC);
      check("seq_plus4", pc_plus4, 32'h10);

      // ---------------- directed vector table ----------------
      //            name          start         br ne z  imm            jmp jt            jr jra           ex stl  exp_pc        v
      vecs.push_back(mk("beq_taken",  32'h10, 1,0,1, 32'h1,          0, 26'h0,         0, 32'h0,        0, 0, 32'h18,        1));
      vecs.push_back(mk("beq_not",    32'h10, 1,0,0, 32'h1,          0, 26'h0,         0, 32'h0,        0, 0, 32'h14,        1));
      vecs.push_back(mk("bne_taken",  32'h10, 1,1,0, 32'h1,          0, 26'h0,         0, 32'h0,        0, 0, 32'h18,        1));
      vecs.push_back(mk("bne_not",    32'h10, 1,1,1, 32'h1,          0, 26'h0,         0, 32'h0,        0, 0, 32'h14,        1));
      vecs.push_back(mk("br_neg",     32'h100,1,0,1, 32'hFFFF_FFFF,  0, 26'h0,         0, 32'h0,        0, 0, 32'h100,       1));
      vecs.push_back(mk("br_wrap",    32'hFFFF_FFF0,1,0,1, 32'h3,    0, 26'h0,         0, 32'h0,        0, 0, 32'h0,         1));
      vecs.push_back(mk("jump",       32'h20, 0,0,0, 32'h0,          1, 26'h000_0040,  0, 32'h0,        0, 0, 32'h100,       1));
      vecs.push_back(mk("jr_over_j",  32'h20, 0,0,0, 32'h0,          1, 26'h000_0040,  1, 32'h203,      0, 0, 32'h200,       1));
      vecs.push_back(mk("j_over_br",  32'h20, 1,0,1, 32'h10,         1, 26'h000_0040,  0, 32'h0,        0, 0, 32'h100,       1));
      vecs.push_back(mk("jump_upper", 32'hF000_0000,0,0,0, 32'h0,    1, 26'h3FF_FFFF,  0, 32'h0,        0, 0, 32'hFFFF_FFFC, 1));
      vecs.push_back(mk("seq_wrap",   32'hFFFF_FFFC,0,0,0, 32'h0,    0, 26'h0,         0, 32'h0,        0, 0, 32'h0,         1));
      vecs.push_back(mk("stall_hold", 32'h40, 1,0,1, 32'h5,          1, 26'h1,         1, 32'h80,       0, 1, 32'h40,        1));
      vecs.push_back(mk("exc_stall",  32'h8,  0,0,0, 32'h0,          1, 26'h1,         1, 32'h80,       1, 1, EXC_V,         0));

      foreach (vecs[i]) begin
         goto(vecs[i].start);
         branch = vecs[i].br; branch_ne = vecs[i].ne; zero = vecs[i].z; imm_ext = vecs[i].imm;
         jump = vecs[i].jmp; jump_target = vecs[i].jt; jr = vecs[i].jrq; jr_addr = vecs[i].jra;
         exc = vecs[i].ex; stall = vecs[i].stl;
         tick;
         clear_inputs();
         check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
         check({vecs[i].name, "_valid"}, pc_valid, vecs[i].exp_v);
      end

      // ---------------- exception with stall, then trap recovery and stall hold ----------------
      goto(32'h8);
      exc = 1; stall = 1;
      tick;
      clear_inputs();
      check("exc_epc", epc, 32'h8);
      check("exc_pc", pc, EXC_V);
      check("exc_trap_valid", pc_valid, 1'b0);
      tick;
      check("trap_exit_pc", pc, EXC_V);
      check("trap_exit_valid", pc_valid, 1'b1);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("stall3_pc", pc, EXC_V);
         check("stall3_valid", pc_valid, 1'b1);
      end
      stall = 0;
      tick;
      check("stall_release_pc", pc, EXC_V + 32'd4);
      check("stall_epc_kept", epc, 32'h8);

      // ---------------- reset during TRAP ----------------
      goto(32'h30);
      exc = 1;
      tick;
      exc = 0;
      check("trap_entry_valid", pc_valid, 1'b0);
      rst = 1;
      tick;
      rst = 0;
      check("rst_trap_pc", pc, RST_V);
      check("rst_trap_valid", pc_valid, 1'b0);
      check("rst_trap_epc", epc, 32'h0);
      tick;
      check("rst_trap_run_pc", pc, RST_V);

      // ---------------- reset during stall with exception pending ----------------
      goto(32'h40);
      stall = 1; exc = 1; rst = 1;
      tick;
      clear_inputs(); rst = 0;
      check("rst_stall_pc", pc, RST_V);
      check("rst_stall_epc", epc, 32'h0);
      check("rst_stall_valid", pc_valid, 1'b0);

      // ---------------- return-address stack sequence ----------------
      tick; // BOOT -> RUN at pc 0 with an empty stack
      for (int k = 0; k < 5; k++) begin
         jump_link = 1; jump_target = 26'(k + 1);
         tick;
         check("link_pc", pc, 32'(4 * (k + 1)));
      end
      clear_inputs();
      check("link_ras_nonempty", ras_empty, 1'b0);
      ret_exp = '{32'h14, 32'h10, 32'hC, 32'h8, 32'h500};
      emp_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
         jr = 1; jr_ret = 1; jr_addr = 32'h500;
         tick;
         check("ret_pc", pc, RAS_ON ? ret_exp[k] : 32'h500);
         check("ret_empty", ras_empty, RAS_ON ? emp_exp[k] : 1'b0);
      end
      clear_inputs();

      // ---------------- randomized run against the model ----------------
      rst = 1;
      tick;
      model_reset();
      rst = 0;
      for (int n = 0; n < 600; n++) begin
         check("rnd_pc", pc, m_pc);
         check("rnd_plus4", pc_plus4, m_pc + 32'd4);
         check("rnd_valid", pc_valid, (m_mode == 1) ? 1'b1 : 1'b0);
         check("rnd_epc", epc, m_epc);
         check("rnd_ras_empty", ras_empty, (RAS_ON && m_ras.size() == 0) ? 1'b1 : 1'b0);
         rst         = ($urandom_range(0, 59) == 0);
         exc         = ($urandom_range(0, 15) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         jr          = ($urandom_range(0, 5) == 0);
         jr_ret      = $urandom_range(0, 1) != 0;
         jr_addr     = $urandom;
         jump        = ($urandom_range(0, 5) == 0);
         jump_link   = ($urandom_range(0, 4) == 0);
         jump_target = 26'($urandom);
         branch      = ($urandom_range(0, 2) == 0);
         branch_ne   = $urandom_range(0, 1) != 0;
         zero        = $urandom_range(0, 1) != 0;
         simm        = int'($urandom_range(0, 63)) - 32;
         imm_ext     = 32'(simm);
         model_step();
         tick;
      end
      clear_inputs(); rst = 0;
      check("rnd_final_pc", pc, m_pc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
